// File: rtl/reg_write_arbiter_pkg.sv
// rtl/reg_write_arbiter_pkg.sv - shared CPU package: register names, index type, $zero, arbiter FSM states
package reg_write_arbiter_pkg;

    typedef logic [4:0] reg_idx_t;

    typedef enum logic [4:0] {
        R_ZERO = 5'd0,  R_AT = 5'd1,  R_V0 = 5'd2,  R_V1 = 5'd3,
        R_A0   = 5'd4,  R_A1 = 5'd5,  R_A2 = 5'd6,  R_A3 = 5'd7,
        R_T0   = 5'd8,  R_T1 = 5'd9,  R_T2 = 5'd10, R_T3 = 5'd11,
        R_T4   = 5'd12, R_T5 = 5'd13, R_T6 = 5'd14, R_T7 = 5'd15,
        R_S0   = 5'd16, R_S1 = 5'd17, R_S2 = 5'd18, R_S3 = 5'd19,
        R_S4   = 5'd20, R_S5 = 5'd21, R_S6 = 5'd22, R_S7 = 5'd23,
        R_T8   = 5'd24, R_T9 = 5'd25, R_K0 = 5'd26, R_K1 = 5'd27,
        R_GP   = 5'd28, R_SP = 5'd29, R_FP = 5'd30, R_RA = 5'd31
    } cpu_reg_e;

    localparam reg_idx_t REG_ZERO = reg_idx_t'(R_ZERO);

`ifdef REGARB_STARVE_EN
    typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_FORCE} arb_state_e;
`else
    typedef enum logic {ST_IDLE, ST_PEND} arb_state_e;
`endif

endpackage

// File: rtl/reg_write_arbiter_scoreboard.sv
// rtl/reg_write_arbiter_scoreboard.sv - pending-destination vector and decode hazard detect
module reg_scoreboard
    import reg_write_arbiter_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     set_en,
    input  reg_idx_t set_addr,
    input  logic     clr_en,
    input  reg_idx_t clr_addr,
    input  reg_idx_t id_rs,
    input  reg_idx_t id_rt,
    input  reg_idx_t id_rd,
    output logic     hz_stall
);

    logic [31:0] pending;
    logic [31:0] pending_nxt;

    // Clear first so a same-cycle set of the same register wins.
    always_comb begin
        pending_nxt = pending;
        if (clr_en)
            pending_nxt[clr_addr] = 1'b0;
        if (set_en)
            pending_nxt[set_addr] = 1'b1;
        pending_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            pending <= '0;
        else
            pending <= pending_nxt;
    end

    function automatic logic is_pending(input logic [31:0] vec, input reg_idx_t idx);
        return (idx != REG_ZERO) && vec[idx];
    endfunction

    assign hz_stall = is_pending(pending, id_rs) | is_pending(pending, id_rt) |
                      is_pending(pending, id_rd);

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - register-file write arbiter, writeback vs buffered long-latency result; REGARB_STARVE_EN enables starvation FORCE
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    input  reg_idx_t    wb_addr,
    input  logic [31:0] wb_data,
    input  logic        ll_valid,
    input  reg_idx_t    ll_addr,
    input  logic [31:0] ll_data,
    output logic        ll_ready,
    input  logic        sb_set,
    input  reg_idx_t    sb_addr,
    input  reg_idx_t    id_rs,
    input  reg_idx_t    id_rt,
    input  reg_idx_t    id_rd,
    output logic        hz_stall,
    output logic        rf_we,
    output reg_idx_t    rf_addr,
    output logic [31:0] rf_wdata,
    output logic        wb_hold,
    output logic        err_collision
);

    arb_state_e  state, state_nxt;
    reg_idx_t    buf_addr;
    logic [31:0] buf_data;
    logic        ll_xfer, commit, wb_grant;
    logic        wr_en_nxt;
    reg_idx_t    wr_addr_nxt;
    logic [31:0] wr_data_nxt;

    assign ll_xfer = ll_valid && ll_ready;

`ifdef REGARB_STARVE_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] loss_cnt;
    logic          starved;

    // This loss is the one that brings the count to STARVE_LIMIT.
    assign starved = (state == ST_PEND) && wb_valid && (loss_cnt == CW'(STARVE_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)
            loss_cnt <= '0;
        else if (commit)
            loss_cnt <= '0;
        else if (state == ST_PEND && wb_valid)
            loss_cnt <= loss_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            err_collision <= 1'b0;
        else if (state == ST_FORCE && wb_valid)
            err_collision <= 1'b1;
    end

    assign wb_hold = (state == ST_FORCE);
`else
    localparam int unsigned unused_starve_limit = STARVE_LIMIT;
    assign wb_hold       = 1'b0;
    assign err_collision = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (ll_xfer) state_nxt = ST_PEND;
            ST_PEND: begin
                if (commit)
                    state_nxt = ST_IDLE;
`ifdef REGARB_STARVE_EN
                else if (starved)
                    state_nxt = ST_FORCE;
`endif
            end
`ifdef REGARB_STARVE_EN
            ST_FORCE: state_nxt = ST_IDLE;
`endif
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        wb_grant = wb_valid;
        commit   = 1'b0;
        case (state)
            ST_PEND:  commit = !wb_valid;
`ifdef REGARB_STARVE_EN
            ST_FORCE: begin
                commit   = 1'b1;
                wb_grant = 1'b0;
            end
`endif
            default: ;
        endcase
        wr_addr_nxt = wb_grant ? wb_addr : buf_addr;
        wr_data_nxt = wb_grant ? wb_data : buf_data;
        wr_en_nxt   = (wb_grant || commit) && (wr_addr_nxt != REG_ZERO);
    end

    // ll_ready mirrors "buffer empty" one cycle ahead via state_nxt.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ll_ready <= 1'b1;
            buf_addr <= REG_ZERO;
            buf_data <= '0;
            rf_we    <= 1'b0;
            rf_addr  <= REG_ZERO;
            rf_wdata <= '0;
        end else begin
            ll_ready <= (state_nxt == ST_IDLE);
            if (ll_xfer) begin
                buf_addr <= ll_addr;
                buf_data <= ll_data;
            end
            rf_we <= wr_en_nxt;
            if (wr_en_nxt) begin
                rf_addr  <= wr_addr_nxt;
                rf_wdata <= wr_data_nxt;
            end
        end
    end

    reg_scoreboard u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (sb_set),
        .set_addr (sb_addr),
        .clr_en   (commit),
        .clr_addr (buf_addr),
        .id_rs    (id_rs),
        .id_rt    (id_rt),
        .id_rd    (id_rd),
        .hz_stall (hz_stall)
    );

endmodule
